ddr3_rw_arbiter: RTL and testbench

DDR3_RW_ARBITER -- requirements
Module: ddr3_rw_arbiter

---
 rtl/ddr3_pkg.sv | 22 ++
 rtl/ddr3_addr_ring.sv | 37 +++
 rtl/ddr3_rw_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
//------------------------------------------------------------------------------
// Module  : ddr3_pkg
// Brief   : Shared arbiter state enumeration and DDR3 app_cmd encodings.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ddr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

endpackage

`default_nettype wire

// File: rtl/ddr3_addr_ring.sv
//------------------------------------------------------------------------------
// Module  : ddr3_addr_ring
// Brief   : Ring-buffer beat pointer: steps by ADDR_STEP, wraps END->BASE.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_addr_ring #(
  parameter int                 ADDR_WD   = 28,
  parameter int                 ADDR_STEP = 8,
  parameter logic [ADDR_WD-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_WD-1:0] END_ADDR  = ADDR_WD'(-ADDR_STEP)
) (
  input  logic               clk_ref,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  output logic [ADDR_WD-1:0] ptr
);

  logic [ADDR_WD-1:0] r_ptr;

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_ptr <= BASE_ADDR;
    end else if (load) begin
      r_ptr <= BASE_ADDR;
    end else if (step) begin
      r_ptr <= (r_ptr == END_ADDR) ? BASE_ADDR : r_ptr + ADDR_WD'(ADDR_STEP);
    end
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/ddr3_rw_arbiter.sv
//------------------------------------------------------------------------------
// Module  : ddr3_rw_arbiter
// Brief   : Round-robin burst arbiter between a write FIFO and a read FIFO
//           sharing one DDR3 ring buffer through the MIG app interface.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter int                 ADDR_WD   = 28,
  parameter int                 BURST_LEN = 64,
  parameter int                 ADDR_STEP = 8,
  parameter logic [ADDR_WD-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_WD-1:0] END_ADDR  = ADDR_WD'(-ADDR_STEP)
) (
  input  logic               clk_ref,
  input  logic               rst,
  input  logic               init_done,
  input  logic               wr_req,
  output logic               wr_ack,
  input  logic               rd_req,
  output logic               rd_ack,
  input  logic               wr_load,
  input  logic               rd_load,
  output logic [2:0]         app_cmd,
  output logic               app_en,
  output logic [ADDR_WD-1:0] app_addr,
  input  logic               app_rdy,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  input  logic               app_wdf_rdy,
  input  logic               app_rd_data_valid
);

  localparam int CAP     = int'((END_ADDR - BASE_ADDR) / ADDR_STEP) + 1;
  localparam int FILL_WD = $clog2(CAP + 1);
  localparam int CNT_WD  = $clog2(BURST_LEN + 1);

  state_t              r_state, w_state_nxt;
  logic [FILL_WD-1:0]  r_fill, w_fill_arb;
  logic [CNT_WD-1:0]   r_beat_cnt, r_ret_cnt, w_ret_cnt_nxt;
  logic                r_last_wr;
  logic                r_wr_load_pend, r_rd_load_pend;
  logic [ADDR_WD-1:0]  w_wr_ptr, w_rd_ptr;
  logic                w_idle, w_apply_wr, w_apply_rd;
  logic                w_wr_elig, w_rd_elig;
  logic                w_wr_acc, w_rd_acc, w_rd_ret;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_apply_wr = w_idle & (r_wr_load_pend | wr_load);
  assign w_apply_rd = w_idle & (r_rd_load_pend | rd_load);
  // Loads are applied before arbitrating, so eligibility sees the cleared fill.
  assign w_fill_arb = (w_apply_wr | w_apply_rd) ? '0 : r_fill;
  assign w_wr_elig  = wr_req & (w_fill_arb <= FILL_WD'(CAP - BURST_LEN));
  assign w_rd_elig  = rd_req & (w_fill_arb >= FILL_WD'(BURST_LEN));

  assign w_wr_acc      = (r_state == ST_WRITE) & app_rdy & app_wdf_rdy;
  assign w_rd_acc      = (r_state == ST_READ) & app_rdy;
  assign w_rd_ret      = ((r_state == ST_READ) | (r_state == ST_RD_WAIT)) & app_rd_data_valid;
  assign w_ret_cnt_nxt = r_ret_cnt + CNT_WD'(w_rd_ret);

  always_comb begin
    w_state_nxt  = r_state;
    app_cmd      = CMD_WR;
    app_en       = 1'b0;
    app_addr     = BASE_ADDR;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wr_ack       = 1'b0;
    rd_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_done) begin
          if (w_wr_elig && (!w_rd_elig || !r_last_wr)) begin
            w_state_nxt = ST_WRITE;
          end else if (w_rd_elig) begin
            w_state_nxt = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        app_en       = 1'b1;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_addr     = w_wr_ptr;
        wr_ack       = w_wr_acc;
        if (w_wr_acc && (r_beat_cnt == CNT_WD'(BURST_LEN - 1))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        app_en   = 1'b1;
        app_cmd  = CMD_RD;
        app_addr = w_rd_ptr;
        rd_ack   = app_rd_data_valid;
        if (w_rd_acc && (r_beat_cnt == CNT_WD'(BURST_LEN - 1))) begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        rd_ack = app_rd_data_valid;
        if (w_ret_cnt_nxt >= CNT_WD'(BURST_LEN)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_fill         <= '0;
      r_beat_cnt     <= '0;
      r_ret_cnt      <= '0;
      r_last_wr      <= 1'b0;
      r_wr_load_pend <= 1'b0;
      r_rd_load_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_idle) begin
        r_beat_cnt <= '0;
        r_ret_cnt  <= '0;
      end else begin
        if (w_wr_acc || w_rd_acc) r_beat_cnt <= r_beat_cnt + CNT_WD'(1);
        if (w_rd_ret) r_ret_cnt <= w_ret_cnt_nxt;
      end

      if (w_idle && (w_state_nxt == ST_WRITE)) r_last_wr <= 1'b1;
      else if (w_idle && (w_state_nxt == ST_READ)) r_last_wr <= 1'b0;

      if (w_apply_wr || w_apply_rd) r_fill <= '0;
      else if (w_wr_acc) r_fill <= r_fill + FILL_WD'(1);
      else if (w_rd_acc) r_fill <= r_fill - FILL_WD'(1);

      // A load seen mid-burst waits for the next IDLE cycle.
      if (w_idle) begin
        r_wr_load_pend <= 1'b0;
        r_rd_load_pend <= 1'b0;
      end else begin
        if (wr_load) r_wr_load_pend <= 1'b1;
        if (rd_load) r_rd_load_pend <= 1'b1;
      end
    end
  end

  ddr3_addr_ring #(
    .ADDR_WD  (ADDR_WD),
    .ADDR_STEP(ADDR_STEP),
    .BASE_ADDR(BASE_ADDR),
    .END_ADDR (END_ADDR)
  ) u_wr_ring (
    .clk_ref(clk_ref),
    .rst    (rst),
    .load   (w_apply_wr),
    .step   (w_wr_acc),
    .ptr    (w_wr_ptr)
  );

  ddr3_addr_ring #(
    .ADDR_WD  (ADDR_WD),
    .ADDR_STEP(ADDR_STEP),
    .BASE_ADDR(BASE_ADDR),
    .END_ADDR (END_ADDR)
  ) u_rd_ring (
    .clk_ref(clk_ref),
    .rst    (rst),
    .load   (w_apply_rd),
    .step   (w_rd_acc),
    .ptr    (w_rd_ptr)
  );

endmodule

`default_nettype wire

// File: tb/tb_ddr3_rw_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_ddr3_rw_arbiter
// Brief   : Randomized bench for ddr3_rw_arbiter against a burst-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr3_rw_arbiter;

  localparam int         AW   = 8;
  localparam int         BL   = 4;
  localparam int         STEP = 8;
  localparam int         CAP  = 8;
  localparam logic [7:0] BASE = 8'd0;
  localparam logic [7:0] ENDA = 8'd56;

  logic          clk_ref = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0, wr_load = 1'b0, rd_load = 1'b0;
  logic          app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0;
  logic          wr_ack, rd_ack, app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;

  always #5 clk_ref = ~clk_ref;

  ddr3_rw_arbiter #(
    .ADDR_WD(AW), .BURST_LEN(BL), .ADDR_STEP(STEP), .BASE_ADDR(BASE), .END_ADDR(ENDA)
  ) dut (
    .clk_ref(clk_ref), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .wr_ack(wr_ack), .rd_req(rd_req), .rd_ack(rd_ack),
    .wr_load(wr_load), .rd_load(rd_load),
    .app_cmd(app_cmd), .app_en(app_en), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Burst-level model: kind 0 = no burst, 1 = write burst, 2 = read burst.
  // Beat indices count freely; addresses come from the index modulo CAP.
  int m_kind, m_left, m_ret, m_wr_idx, m_rd_idx, m_fill;
  bit m_last_wr, m_pw, m_pr;

  task automatic model_reset();
    m_kind = 0; m_left = 0; m_ret = 0; m_wr_idx = 0; m_rd_idx = 0; m_fill = 0;
    m_last_wr = 1'b0; m_pw = 1'b0; m_pr = 1'b0;
  endtask

  function automatic int outstanding();
    return (m_kind == 2) ? (BL - m_left) - m_ret : 0;
  endfunction

  task automatic check_outputs();
    logic exp_en, exp_wdf, exp_wack, exp_rack;
    int   exp_cmd, exp_addr;
    exp_en = 0; exp_wdf = 0; exp_wack = 0; exp_rack = 0; exp_cmd = 0; exp_addr = BASE;
    if (m_kind == 1) begin
      exp_en = 1; exp_wdf = 1; exp_wack = app_rdy & app_wdf_rdy;
      exp_addr = BASE + (m_wr_idx % CAP) * STEP;
    end else if (m_kind == 2) begin
      exp_rack = app_rd_data_valid;
      if (m_left > 0) begin
        exp_en = 1; exp_cmd = 1; exp_addr = BASE + (m_rd_idx % CAP) * STEP;
      end
    end
    check_val("app_en", app_en, exp_en);
    check_val("app_cmd", app_cmd, exp_cmd);
    check_val("app_addr", app_addr, exp_addr);
    check_val("app_wdf_wren", app_wdf_wren, exp_wdf);
    check_val("app_wdf_end", app_wdf_end, exp_wdf);
    check_val("wr_ack", wr_ack, exp_wack);
    check_val("rd_ack", rd_ack, exp_rack);
    check_val("fill", dut.r_fill, m_fill);
  endtask

  task automatic model_update();
    bit we, re, waiting;
    int pick;
    if (m_kind == 0) begin
      if (m_pw || wr_load) begin m_wr_idx = 0; m_fill = 0; end
      if (m_pr || rd_load) begin m_rd_idx = 0; m_fill = 0; end
      m_pw = 0; m_pr = 0;
      if (init_done) begin
        we = wr_req && (m_fill <= CAP - BL);
        re = rd_req && (m_fill >= BL);
        pick = (we && re) ? (m_last_wr ? 2 : 1) : (we ? 1 : (re ? 2 : 0));
        if (pick != 0) begin
          m_kind = pick; m_left = BL; m_ret = 0; m_last_wr = (pick == 1);
        end
      end
    end else begin
      if (wr_load) m_pw = 1;
      if (rd_load) m_pr = 1;
      if (m_kind == 1) begin
        if (app_rdy && app_wdf_rdy) begin
          m_wr_idx++; m_fill++; m_left--;
          if (m_left == 0) m_kind = 0;
        end
      end else begin
        waiting = (m_left == 0);
        if (app_rd_data_valid) m_ret++;
        if (!waiting && app_rdy) begin m_rd_idx++; m_fill--; m_left--; end
        if (waiting && m_ret >= BL) m_kind = 0;
      end
    end
  endtask

  task automatic step(input bit idn, input bit wq, input bit rq, input bit wl, input bit rl,
                      input bit ar, input bit wr, input bit vd);
    @(negedge clk_ref);
    init_done = idn; wr_req = wq; rd_req = rq; wr_load = wl; rd_load = rl;
    app_rdy = ar; app_wdf_rdy = wr; app_rd_data_valid = vd;
    #1;
    check_outputs();
    @(posedge clk_ref);
    model_update();
  endtask

  initial begin
    bit vd;
    int guard;
    model_reset();
    #12;
    check_val("rst_app_en", app_en, 0);
    check_val("rst_app_addr", app_addr, BASE);
    check_val("rst_wr_ack", wr_ack, 0);
    @(negedge clk_ref);
    rst = 1'b0;

    // Calibration not done: requests must be ignored.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 1, 1, 0);

    // Plain write burst: 4 beats at 0,8,16,24.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 1, 1, 0);
    check_val("fill_after_wr", dut.r_fill, 4);

    // Both requesting after a write grant: read wins; returns trickle in.
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 1, 1, (outstanding() > 0) && (i % 2 == 0));

    // Randomized traffic with occasional loads and stalls.
    for (int i = 0; i < 3000; i++) begin
      vd = (outstanding() > 0) && ($urandom_range(0, 3) != 0);
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 6) != 0, vd);
    end

    // Drive into a read burst waiting on data, then reset asynchronously.
    guard = 0;
    while (m_kind != 0 && guard < 100) begin
      step(1, 0, 0, 0, 0, 1, 1, outstanding() > 0); guard++;
    end
    step(1, 0, 0, 0, 1, 1, 1, 0);
    guard = 0;
    while (!(m_kind == 0 && m_fill >= BL) && guard < 100) begin
      step(1, 1, 0, 0, 0, 1, 1, 0); guard++;
    end
    guard = 0;
    while (!(m_kind == 2 && m_left == 0) && guard < 100) begin
      step(1, 0, 1, 0, 0, 1, 1, 0); guard++;
    end
    check_val("reach_rd_wait", (m_kind == 2 && m_left == 0), 1);
    #2;
    app_rd_data_valid = 1'b1;
    #1;
    check_val("rd_wait_rd_ack", rd_ack, 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_rd_ack", rd_ack, 0);
    check_val("mid_rst_app_en", app_en, 0);
    check_val("mid_rst_app_addr", app_addr, BASE);
    check_val("mid_rst_wr_ptr", dut.u_wr_ring.r_ptr, BASE);
    check_val("mid_rst_rd_ptr", dut.u_rd_ring.r_ptr, BASE);
    check_val("mid_rst_fill", dut.r_fill, 0);
    model_reset();
    app_rd_data_valid = 1'b0;
    @(negedge clk_ref);
    rst = 1'b0;

    // Contested grant right after reset goes to write.
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
